y_capture_streamer: RTL



---
 rtl/ycap_pkg.sv | 9 +
 rtl/y_capture_streamer_misr_step.sv | 11 +
 rtl/y_capture_streamer.sv | 87 ++++++++
 3 files changed

// File: rtl/ycap_pkg.sv
// ycap_pkg: shared state encoding, beat-count helper and MISR defaults for the y capture streamer
package ycap_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, SIGN} state_t;
  localparam logic [31:0] DEF_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEF_SEED = 32'h00000000;
  function automatic int nbeats(input int yw, input int cw);
    return (yw + cw - 1) / cw;
  endfunction
endpackage

// File: rtl/y_capture_streamer_misr_step.sv
// misr_step: combinational next-signature function of a W-bit MISR
module misr_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] sig,
  input  logic [W-1:0] data,
  input  logic [W-1:0] poly,
  output logic [W-1:0] sig_next
);
  always_comb sig_next = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? poly : '0) ^ data;
endmodule

// File: rtl/y_capture_streamer.sv
// y_capture_streamer: latches y and streams it as CHUNK-bit beats followed by a MISR signature beat
module y_capture_streamer
  import ycap_pkg::*;
#(
  parameter int Y_WIDTH = 867,
  parameter int CHUNK = 32,
  parameter logic [CHUNK-1:0] POLY = CHUNK'(DEF_POLY),
  parameter logic [CHUNK-1:0] SEED = CHUNK'(DEF_SEED)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [Y_WIDTH-1:0] y_in,
  input  logic               cap_req,
  output logic               cap_busy,
  output logic [CHUNK-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               out_is_sig,
  output logic [CHUNK-1:0]   sig,
  output logic               overrun,
  output logic [15:0]        cap_count
);
  localparam int NB = nbeats(Y_WIDTH, CHUNK);
  localparam int PW = NB * CHUNK;
  localparam int IW = $clog2(NB + 1);
  state_t state;
  logic [PW-1:0] y_cap;
  logic [PW-1:0] y_pad;
  logic [IW-1:0] idx;
  logic [CHUNK-1:0] sig_next;
  logic hs, take, ovr_hit, last_beat;
  misr_step #(.W(CHUNK)) u_misr (
    .sig(sig),
    .data(out_data),
    .poly(POLY),
    .sig_next(sig_next)
  );
  always_comb begin
    y_pad = PW'(y_in);
    hs = out_valid & out_ready;
    take = cap_req & ((state == IDLE) | ((state == SIGN) & hs));
    ovr_hit = cap_req & (state != IDLE) & ~take;
    last_beat = idx == IW'(NB - 1);
    cap_busy = state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      y_cap <= '0;
      idx <= '0;
      sig <= SEED;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      out_is_sig <= 1'b0;
      overrun <= 1'b0;
      cap_count <= '0;
    end else begin
      if (ovr_hit) overrun <= 1'b1;
      if (take) begin
        state <= STREAM;
        y_cap <= y_pad >> CHUNK;
        idx <= '0;
        sig <= SEED;
        cap_count <= cap_count + 1'b1;
        out_data <= y_pad[CHUNK-1:0];
        out_valid <= 1'b1;
        out_last <= 1'b0;
        out_is_sig <= 1'b0;
      end else if (hs && state == STREAM) begin
        sig <= sig_next;
        idx <= idx + 1'b1;
        y_cap <= y_cap >> CHUNK;
        out_data <= last_beat ? sig_next : y_cap[CHUNK-1:0];
        out_last <= last_beat;
        out_is_sig <= last_beat;
        if (last_beat) state <= SIGN;
      end else if (hs && state == SIGN) begin
        state <= IDLE;
        out_valid <= 1'b0;
        out_last <= 1'b0;
        out_is_sig <= 1'b0;
      end
    end
  end
endmodule
